// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared opcodes, ALU operation codes and control struct for the decode stage
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_CMP = 3'd6;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src2;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       zero_ext;
    logic       illegal;
  } ctrl_t;

  // Instructions whose rt field is a source register and so can hit a load-use hazard
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_ctrl_rom.sv
// rtl/id_ctrl_rom.sv - combinational opcode/funct to control-struct decode
module id_ctrl_rom
  import id_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        case (i_funct)
          FN_ADD: o_ctrl.alu_op = ALU_ADD;
          FN_SUB: o_ctrl.alu_op = ALU_SUB;
          FN_AND: o_ctrl.alu_op = ALU_AND;
          FN_OR:  o_ctrl.alu_op = ALU_OR;
          FN_SLT: o_ctrl.alu_op = ALU_SLT;
          default: begin
            o_ctrl         = '0;
            o_ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        o_ctrl.alu_op     = ALU_ADD;
        o_ctrl.alu_src2   = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.alu_src2  = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.alu_src2  = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_SLTI: begin
        o_ctrl.alu_op    = ALU_SLT;
        o_ctrl.alu_src2  = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_ANDI: begin
        o_ctrl.alu_op    = ALU_AND;
        o_ctrl.alu_src2  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.zero_ext  = 1'b1;
      end
      OP_ORI: begin
        o_ctrl.alu_op    = ALU_OR;
        o_ctrl.alu_src2  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.zero_ext  = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.alu_op = ALU_CMP;
        o_ctrl.branch = 1'b1;
      end
      OP_BNE: begin
        o_ctrl.alu_op    = ALU_CMP;
        o_ctrl.branch    = 1'b1;
        o_ctrl.branch_ne = 1'b1;
      end
      OP_J: begin
        o_ctrl.jump = 1'b1;
      end
      default: begin
        o_ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage_decoder.sv
// rtl/id_stage_decoder.sv - registered decode stage with load-use bubbles, flush and stall counter
// ID_ILLEGAL_TRAP_EN: illegal instructions are consumed without a bundle and set sticky illegal_o.
module id_stage_decoder
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         rs_o,
  output logic [4:0]         rt_o,
  output logic [4:0]         rd_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [25:0]        jump_target_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               alu_src2_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               mem_to_reg_o,
  output logic               branch_o,
  output logic               branch_ne_o,
  output logic               jump_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic               r_valid;
  logic [4:0]         r_rs;
  logic [4:0]         r_rt;
  logic [4:0]         r_rd;
  logic [DATA_W-1:0]  r_imm;
  logic [25:0]        r_jump_target;
  logic [ALUOP_W-1:0] r_alu_op;
  logic               r_alu_src2;
  logic               r_reg_write;
  logic               r_reg_dst;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_mem_to_reg;
  logic               r_branch;
  logic               r_branch_ne;
  logic               r_jump;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_stall_cnt;

  ctrl_t              w_ctrl;
  logic [5:0]         w_op;
  logic [4:0]         w_src_rs;
  logic [4:0]         w_src_rt;
  logic               w_hazard;
  logic               w_accept;
  logic               w_bubble;
  logic [DATA_W-1:0]  w_imm;

  assign w_op     = in_instr[31:26];
  assign w_src_rs = in_instr[25:21];
  assign w_src_rt = in_instr[20:16];

  id_ctrl_rom u_ctrl_rom (
    .i_opcode (w_op),
    .i_funct  (in_instr[5:0]),
    .o_ctrl   (w_ctrl)
  );

  // Hazard is computed from the instruction bits alone so in_ready never looks at in_valid
  assign w_hazard = r_valid && r_mem_read && (r_rd != 5'd0) &&
                    ((r_rd == w_src_rs) || (reads_rt(w_op) && (r_rd == w_src_rt)));

  assign in_ready = flush || ((!r_valid || out_ready) && !w_hazard);
  assign w_accept = in_valid && in_ready;
  assign w_bubble = in_valid && w_hazard && out_ready;

  assign w_imm = w_ctrl.zero_ext ? DATA_W'(in_instr[15:0])
                                 : DATA_W'($signed(in_instr[15:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_rd          <= '0;
      r_imm         <= '0;
      r_jump_target <= '0;
      r_alu_op      <= '0;
      r_alu_src2    <= 1'b0;
      r_reg_write   <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_branch      <= 1'b0;
      r_branch_ne   <= 1'b0;
      r_jump        <= 1'b0;
      r_illegal     <= 1'b0;
      r_stall_cnt   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_bubble) begin
      r_valid <= 1'b0;
      if (r_stall_cnt != {CNT_W{1'b1}}) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end else if (w_accept) begin
      if (TRAP_EN && w_ctrl.illegal) begin
        r_valid   <= 1'b0;
        r_illegal <= 1'b1;
      end else begin
        r_valid       <= 1'b1;
        r_rs          <= w_src_rs;
        r_rt          <= w_src_rt;
        r_rd          <= w_ctrl.reg_dst ? in_instr[15:11] : w_src_rt;
        r_imm         <= w_imm;
        r_jump_target <= in_instr[25:0];
        r_alu_op      <= ALUOP_W'(w_ctrl.alu_op);
        r_alu_src2    <= w_ctrl.alu_src2;
        r_reg_write   <= w_ctrl.reg_write;
        r_reg_dst     <= w_ctrl.reg_dst;
        r_mem_read    <= w_ctrl.mem_read;
        r_mem_write   <= w_ctrl.mem_write;
        r_mem_to_reg  <= w_ctrl.mem_to_reg;
        r_branch      <= w_ctrl.branch;
        r_branch_ne   <= w_ctrl.branch_ne;
        r_jump        <= w_ctrl.jump;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign rs_o          = r_rs;
  assign rt_o          = r_rt;
  assign rd_o          = r_rd;
  assign imm_o         = r_imm;
  assign jump_target_o = r_jump_target;
  assign alu_op_o      = r_alu_op;
  assign alu_src2_o    = r_alu_src2;
  assign reg_write_o   = r_reg_write;
  assign reg_dst_o     = r_reg_dst;
  assign mem_read_o    = r_mem_read;
  assign mem_write_o   = r_mem_write;
  assign mem_to_reg_o  = r_mem_to_reg;
  assign branch_o      = r_branch;
  assign branch_ne_o   = r_branch_ne;
  assign jump_o        = r_jump;
  assign illegal_o     = r_illegal;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_decoder.sv
// tb/tb_id_stage_decoder.sv - directed and randomized self-checking bench for id_stage_decoder
module tb_id_stage_decoder;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [25:0] jt;
    logic [3:0]  alu;
    logic        src2, rw, rdst, mr, mw, m2r, br, bne, jmp;
  } bundle_t;

`ifdef ID_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [31:0] imm_o;
  logic [25:0] jump_target_o;
  logic [3:0]  alu_op_o;
  logic        alu_src2_o, reg_write_o, reg_dst_o, mem_read_o, mem_write_o;
  logic        mem_to_reg_o, branch_o, branch_ne_o, jump_o, illegal_o;
  logic [15:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  bit      m_valid;
  bundle_t m_b;
  int      m_cnt;
  bit      m_ill;

  always #5 clk = ~clk;

  id_stage_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .imm_o(imm_o), .jump_target_o(jump_target_o),
    .alu_op_o(alu_op_o), .alu_src2_o(alu_src2_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o), .branch_ne_o(branch_ne_o),
    .jump_o(jump_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the instruction table
  function automatic bundle_t ref_dec(input logic [31:0] ins, output bit ill);
    bundle_t e;
    logic [5:0] op;
    logic [5:0] fn;
    op  = ins[31:26];
    fn  = ins[5:0];
    e   = '0;
    ill = 1'b0;
    e.rs  = ins[25:21];
    e.rt  = ins[20:16];
    e.jt  = ins[25:0];
    e.imm = {{16{ins[15]}}, ins[15:0]};
    case (op)
      6'h00: begin
        case (fn)
          6'h20: e.alu = 4'd0;
          6'h22: e.alu = 4'd1;
          6'h24: e.alu = 4'd2;
          6'h25: e.alu = 4'd3;
          6'h2A: e.alu = 4'd4;
          default: ill = 1'b1;
        endcase
        if (!ill) begin e.rdst = 1; e.rw = 1; end
      end
      6'h23: begin e.src2 = 1; e.mr = 1; e.m2r = 1; e.rw = 1; end
      6'h2B: begin e.src2 = 1; e.mw = 1; end
      6'h08: begin e.src2 = 1; e.rw = 1; end
      6'h0A: begin e.alu = 4'd4; e.src2 = 1; e.rw = 1; end
      6'h0C: begin e.alu = 4'd2; e.src2 = 1; e.rw = 1; e.imm = {16'h0, ins[15:0]}; end
      6'h0D: begin e.alu = 4'd3; e.src2 = 1; e.rw = 1; e.imm = {16'h0, ins[15:0]}; end
      6'h04: begin e.alu = 4'd6; e.br = 1; end
      6'h05: begin e.alu = 4'd6; e.br = 1; e.bne = 1; end
      6'h02: e.jmp = 1;
      default: ill = 1'b1;
    endcase
    e.rd = e.rdst ? ins[15:11] : ins[20:16];
    return e;
  endfunction

  function automatic bundle_t observed();
    bundle_t o;
    o.rs = rs_o; o.rt = rt_o; o.rd = rd_o; o.imm = imm_o; o.jt = jump_target_o;
    o.alu = alu_op_o; o.src2 = alu_src2_o; o.rw = reg_write_o; o.rdst = reg_dst_o;
    o.mr = mem_read_o; o.mw = mem_write_o; o.m2r = mem_to_reg_o; o.br = branch_o;
    o.bne = branch_ne_o; o.jmp = jump_o;
    return o;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0] a, b, c;
    logic [15:0] im;
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    a  = 5'($urandom_range(0, 3));
    b  = 5'($urandom_range(0, 3));
    c  = 5'($urandom_range(0, 3));
    im = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return {6'h00, a, b, c, 5'd0, fns[$urandom_range(0, 4)]};
      1:  return {6'h00, a, b, c, 5'd0, 6'h21};
      2:  return {6'h23, a, b, im};
      3:  return {6'h2B, a, b, im};
      4:  return {6'h08, a, b, im};
      5:  return {6'h0A, a, b, im};
      6:  return {6'h0C, a, b, im};
      7:  return {6'h0D, a, b, im};
      8:  return {6'h04, a, b, im};
      9:  return {6'h05, a, b, im};
      10: return {6'h02, 26'($urandom)};
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("illegal_o", illegal_o, m_ill);
    chk("stall_cnt", stall_cnt_o, m_cnt);
    if (m_valid) chk("bundle", observed(), m_b);
  endtask

  // One clock: drive at posedge+1, check in_ready, then check registered outputs at posedge+1
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic ordy);
    bit hz, rdy, ill;
    bit rt_src;
    bundle_t d;
    in_valid = v; in_instr = ins; flush = fl; out_ready = ordy;
    #1;
    rt_src = ins[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B};
    hz  = m_valid && m_b.mr && (m_b.rd != 0) &&
          ((m_b.rd == ins[25:21]) || (rt_src && (m_b.rd == ins[20:16])));
    rdy = fl || ((!m_valid || ordy) && !hz);
    if (v) chk("in_ready", in_ready, rdy);
    @(posedge clk);
    if (fl) m_valid = 0;
    else if (v && hz && ordy) begin
      m_valid = 0;
      if (m_cnt < 65535) m_cnt++;
    end else if (v && rdy) begin
      d = ref_dec(ins, ill);
      if (TRAP && ill) begin m_valid = 0; m_ill = 1; end
      else begin m_valid = 1; m_b = d; end
    end else if (ordy) m_valid = 0;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_bundle", observed(), '0);
    chk("rst_illegal", illegal_o, 1'b0);
    chk("rst_cnt", stall_cnt_o, 16'd0);
    @(negedge clk);
    rst_n = 1;
    m_valid = 0; m_b = '0; m_cnt = 0; m_ill = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    step(1, 32'h00221820, 0, 1);
    chk("add_valid", out_valid, 1'b1);
    chk("add_rs", rs_o, 5'd1);
    chk("add_rt", rt_o, 5'd2);
    chk("add_rd", rd_o, 5'd3);
    chk("add_flags", {reg_dst_o, reg_write_o}, 2'b11);
    chk("add_alu", alu_op_o, 4'd0);

    step(1, 32'h8C220004, 0, 1);
    step(1, 32'h00411820, 0, 1);
    chk("bubble_valid", out_valid, 1'b0);
    chk("bubble_cnt", stall_cnt_o, 16'd1);
    step(1, 32'h00411820, 0, 1);
    chk("after_bubble_rd", {out_valid, rd_o}, {1'b1, 5'd3});
    step(1, 32'h8C200004, 0, 1);
    step(1, 32'h00011820, 0, 1);
    chk("r0_no_bubble", {out_valid, stall_cnt_o}, {1'b1, 16'd1});

    step(1, 32'h2008FFFF, 0, 1);
    chk("addi_imm", imm_o, 32'hFFFFFFFF);
    step(1, 32'h3408FFFF, 0, 1);
    chk("ori_imm", imm_o, 32'h0000FFFF);
    step(1, 32'h1022FFFE, 0, 1);
    chk("beq", {branch_o, imm_o}, {1'b1, 32'hFFFFFFFE});

    step(1, 32'h00853020, 0, 1);
    repeat (3) begin
      step(1, 32'h01094020, 0, 0);
      chk("bp_hold", {out_valid, rd_o}, {1'b1, 5'd6});
    end
    step(1, 32'h01094020, 0, 1);
    chk("bp_release", {out_valid, rd_o}, {1'b1, 5'd8});
    step(0, 32'h0, 0, 1);

    step(1, 32'h00221820, 0, 1);
    step(1, 32'h00853020, 1, 0);
    chk("flush_valid", out_valid, 1'b0);
    step(0, 32'h0, 0, 1);
    chk("flush_dropped", out_valid, 1'b0);

    step(1, 32'hFC000000, 0, 1);
`ifdef ID_ILLEGAL_TRAP_EN
    chk("trap", {illegal_o, out_valid}, 2'b10);
`else
    chk("illegal_nop", {illegal_o, out_valid, reg_write_o}, 3'b010);
`endif

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 8, rnd_instr(), $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7);
    end

    step(1, 32'h8C220004, 0, 1);
    in_valid = 1; in_instr = 32'h00221820; out_ready = 1;
    #2;
    rst_n = 0;
    #1;
    chk("async_valid", out_valid, 1'b0);
    chk("async_bundle", observed(), '0);
    chk("async_cnt", {illegal_o, stall_cnt_o}, 17'd0);
    do_reset();

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 8, rnd_instr(), $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
